tour_cmd_seq: RTL and testbench

- Parametrised successor to the tour command sequencer.
- Sits between the tour solver (move memory), the UART command wrapper and cmd_proc.
- While idle, passes UART commands through to cmd_proc.
- Once a tour starts, expands each stored one-hot knight move into two motion commands (long leg, short leg) and handshakes each with cmd_proc. Leg order is selectable, and illegal move codes are detected.

---
 rtl/tour_cmd_seq.sv | 162 ++++++++++++++++
 tb/tb_tour_cmd_seq.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/tour_cmd_seq.sv
// tour_cmd_seq: sits between the tour solver's move memory, the UART command
// wrapper and cmd_proc.
//
// While idle it passes UART commands straight through to cmd_proc. During a
// tour it expands each one-hot knight move into two motion commands: a
// 2-square long leg and a 1-square short leg. Each command is handshaked
// with cmd_proc. leg_order selects which leg goes first. A move code that is
// not exactly one-hot sends the sequencer to ERR.
//
// Optional build macro TOUR_ABORT_EN: when defined, a UART command with
// opcode 4'hF received during a tour aborts the tour. The abort command is
// not forwarded to cmd_proc.
//
// state | meaning
// IDLE  | UART pass-through, waiting for start_tour
// LEG1  | first leg of move[mv_indx] presented to cmd_proc
// WAIT1 | first leg accepted, waiting for cmd_proc to finish it
// LEG2  | second leg presented to cmd_proc
// WAIT2 | second leg accepted, waiting for cmd_proc to finish it
// ERR   | illegal move code seen, waiting for send_resp or start_tour
module tour_cmd_seq #(
  parameter int         NUM_MOVES = 24,
  parameter int         IDX_W     = 5,
  parameter logic [3:0] OPCODE    = 4'h4,
  parameter logic [7:0] RESP_DONE = 8'hA5,
  parameter logic [7:0] RESP_BUSY = 8'h5A,
  parameter logic [7:0] RESP_ERR  = 8'hEE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_tour,
  input  logic             leg_order,
  input  logic [7:0]       move,
  output logic [IDX_W-1:0] mv_indx,
  input  logic [15:0]      cmd_UART,
  input  logic             cmd_rdy_UART,
  output logic [15:0]      cmd,
  output logic             cmd_rdy,
  input  logic             clr_cmd_rdy,
  input  logic             send_resp,
  output logic [7:0]       resp,
  output logic             tour_busy
);

  localparam logic [7:0] HD_N = 8'h00;
  localparam logic [7:0] HD_W = 8'h3F;
  localparam logic [7:0] HD_S = 8'h7F;
  localparam logic [7:0] HD_E = 8'hBF;

  typedef enum logic [2:0] {IDLE, LEG1, WAIT1, LEG2, WAIT2, ERR} state_t;

  state_t      state;
  logic        order_q;
  logic [11:0] leg1_q, leg2_q;
  logic [11:0] dec_long, dec_short, dec_first, dec_second;
  logic        move_ok, last_move, abort;

  // Decode the one-hot move into {heading, squares} for its long and short legs.
  always_comb begin
    dec_long  = 12'h000;
    dec_short = 12'h000;
    case (move)
      8'h01: begin dec_long = {HD_N, 4'd2}; dec_short = {HD_E, 4'd1}; end
      8'h02: begin dec_long = {HD_N, 4'd2}; dec_short = {HD_W, 4'd1}; end
      8'h04: begin dec_long = {HD_W, 4'd2}; dec_short = {HD_N, 4'd1}; end
      8'h08: begin dec_long = {HD_W, 4'd2}; dec_short = {HD_S, 4'd1}; end
      8'h10: begin dec_long = {HD_S, 4'd2}; dec_short = {HD_W, 4'd1}; end
      8'h20: begin dec_long = {HD_S, 4'd2}; dec_short = {HD_E, 4'd1}; end
      8'h40: begin dec_long = {HD_E, 4'd2}; dec_short = {HD_S, 4'd1}; end
      8'h80: begin dec_long = {HD_E, 4'd2}; dec_short = {HD_N, 4'd1}; end
      default: begin dec_long = 12'h000; dec_short = 12'h000; end
    endcase
  end

  assign dec_first  = order_q ? dec_short : dec_long;
  assign dec_second = order_q ? dec_long  : dec_short;
  assign move_ok    = (move != 8'h00) && ((move & (move - 8'd1)) == 8'h00);
  assign last_move  = (mv_indx == IDX_W'(NUM_MOVES - 1));
  assign tour_busy  = (state != IDLE);

`ifdef TOUR_ABORT_EN
  assign abort = cmd_rdy_UART && (cmd_UART[15:12] == 4'hF) &&
                 (state == LEG1 || state == WAIT1 || state == LEG2 || state == WAIT2);
`else
  assign abort = 1'b0;
`endif

  // Output mux: UART pass-through when idle, otherwise the current leg.
  always_comb begin
    cmd     = 16'h0000;
    cmd_rdy = 1'b0;
    resp    = RESP_BUSY;
    case (state)
      IDLE: begin
        cmd     = cmd_UART;
        cmd_rdy = cmd_rdy_UART;
        resp    = RESP_DONE;
      end
      LEG1: begin
        cmd     = {OPCODE, dec_first};
        cmd_rdy = move_ok && !abort;
      end
      WAIT1: cmd = {OPCODE, leg1_q};
      LEG2: begin
        cmd     = {OPCODE, leg2_q};
        cmd_rdy = !abort;
      end
      WAIT2: begin
        cmd  = {OPCODE, leg2_q};
        resp = last_move ? RESP_DONE : RESP_BUSY;
      end
      ERR: resp = RESP_ERR;
      default: resp = RESP_DONE;
    endcase
  end

  // Sequencer state, move index and leg registers.
  // move is read combinationally at mv_indx, so the legs of the move at the
  // new index are only visible once LEG1 is entered. They are therefore
  // captured on every LEG1 cycle. This keeps cmd stable from WAIT1 through
  // WAIT2, even if move changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      mv_indx <= '0;
      leg1_q  <= 12'h000;
      leg2_q  <= 12'h000;
      order_q <= 1'b0;
    end else if (abort) begin
      state   <= IDLE;
      mv_indx <= '0;
    end else begin
      case (state)
        IDLE: if (start_tour) begin
          state   <= LEG1;
          mv_indx <= '0;
          order_q <= leg_order;
        end
        LEG1: begin
          leg1_q <= dec_first;
          leg2_q <= dec_second;
          if (!move_ok)        state <= ERR;
          else if (clr_cmd_rdy) state <= WAIT1;
        end
        WAIT1: if (send_resp) state <= LEG2;
        LEG2:  if (clr_cmd_rdy) state <= WAIT2;
        WAIT2: if (send_resp) begin
          if (last_move) begin
            state   <= IDLE;
            mv_indx <= '0;
          end else begin
            state   <= LEG1;
            mv_indx <= mv_indx + 1'b1;
          end
        end
        ERR: if (send_resp || start_tour) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tour_cmd_seq.sv
// Bench for tour_cmd_seq with a three-move tour. A model of the move-to-command
// rules drives the expected values; handshake delays and UART noise are random.
module tb_tour_cmd_seq;
  localparam int NM = 3;
  localparam int IW = 2;

  localparam logic [7:0] LONG_HD  [8] = '{8'h00, 8'h00, 8'h3F, 8'h3F, 8'h7F, 8'h7F, 8'hBF, 8'hBF};
  localparam logic [7:0] SHORT_HD [8] = '{8'hBF, 8'h3F, 8'h00, 8'h7F, 8'h3F, 8'hBF, 8'h7F, 8'h00};

  logic          clk = 1'b0;
  logic          rst, start_tour, leg_order, clr_cmd_rdy, send_resp, cmd_rdy_UART;
  logic          cmd_rdy, tour_busy;
  logic [7:0]    move, resp;
  logic [IW-1:0] mv_indx;
  logic [15:0]   cmd_UART, cmd;
  logic [7:0]    mem [4];
  int            total = 0;
  int            bad = 0;

  tour_cmd_seq #(.NUM_MOVES(NM), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .start_tour(start_tour), .leg_order(leg_order),
    .move(move), .mv_indx(mv_indx), .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART),
    .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp),
    .resp(resp), .tour_busy(tour_busy)
  );

  always #5 clk = ~clk;

  // Move memory is read combinationally at the current index.
  always_comb move = mem[mv_indx];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit onehot(input logic [7:0] mv);
    return $countones(mv) == 1;
  endfunction

  // Expected command for one leg of a move, from the move table.
  function automatic logic [15:0] leg_cmd(input logic [7:0] mv, input bit order, input bit second);
    int b = 0;
    for (int k = 0; k < 8; k++) if (mv[k]) b = k;
    if (order ^ second) return {4'h4, SHORT_HD[b], 4'd1};
    return {4'h4, LONG_HD[b], 4'd2};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    cmd_UART     = {4'($urandom_range(0, 14)), 12'($urandom)};
    cmd_rdy_UART = 1'($urandom);
  endtask

  // Drive one complete tour; rst_at selects a move index at which rst is
  // asserted in WAIT2 instead of completing.
  task automatic run_tour(input bit order, input int rst_at);
    logic [15:0] c1, c2;
    logic [7:0]  saved;
    leg_order  = order;
    start_tour = 1'b1;
    step();
    start_tour = 1'b0;
    leg_order  = 1'($urandom);
    for (int i = 0; i < NM; i++) begin
      noise(); #1;
      chk("idx", 32'(mv_indx), 32'(i));
      chk("busy", 32'(tour_busy), 32'd1);
      if (!onehot(mem[i])) begin
        chk("err_entry_rdy", 32'(cmd_rdy), 32'd0);
        step(); noise(); #1;
        chk("err_resp", 32'(resp), 32'hEE);
        chk("err_rdy", 32'(cmd_rdy), 32'd0);
        chk("err_idx", 32'(mv_indx), 32'(i));
        repeat ($urandom_range(0, 3)) begin
          clr_cmd_rdy = 1'($urandom);
          step(); #1;
          chk("err_hold", 32'(resp), 32'hEE);
        end
        clr_cmd_rdy = 1'b0;
        if ($urandom_range(0, 1) == 1) send_resp = 1'b1;
        else start_tour = 1'b1;
        step();
        send_resp = 1'b0; start_tour = 1'b0; #1;
        chk("err_exit_busy", 32'(tour_busy), 32'd0);
        chk("err_exit_resp", 32'(resp), 32'hA5);
        return;
      end
      c1 = leg_cmd(mem[i], order, 1'b0);
      c2 = leg_cmd(mem[i], order, 1'b1);
      repeat ($urandom_range(0, 2)) begin
        chk("leg1_cmd", 32'(cmd), 32'(c1));
        chk("leg1_rdy", 32'(cmd_rdy), 32'd1);
        send_resp = 1'($urandom);
        step(); send_resp = 1'b0; noise(); #1;
      end
      chk("leg1_cmd", 32'(cmd), 32'(c1));
      chk("leg1_rdy", 32'(cmd_rdy), 32'd1);
      clr_cmd_rdy = 1'b1; send_resp = 1'($urandom);
      step();
      clr_cmd_rdy = 1'b0; send_resp = 1'b0;
      saved  = mem[i];
      mem[i] = 8'($urandom);
      #1;
      chk("wait1_cmd", 32'(cmd), 32'(c1));
      chk("wait1_rdy", 32'(cmd_rdy), 32'd0);
      chk("wait1_resp", 32'(resp), 32'h5A);
      repeat ($urandom_range(0, 2)) begin
        clr_cmd_rdy = 1'($urandom); start_tour = 1'($urandom); noise();
        step();
        clr_cmd_rdy = 1'b0; start_tour = 1'b0; #1;
        chk("wait1_hold", 32'(cmd), 32'(c1));
        chk("wait1_rdy", 32'(cmd_rdy), 32'd0);
      end
      send_resp = 1'b1;
      step();
      send_resp = 1'b0; #1;
      chk("leg2_cmd", 32'(cmd), 32'(c2));
      chk("leg2_rdy", 32'(cmd_rdy), 32'd1);
      clr_cmd_rdy = 1'b1;
      step();
      clr_cmd_rdy = 1'b0; #1;
      chk("wait2_cmd", 32'(cmd), 32'(c2));
      chk("wait2_rdy", 32'(cmd_rdy), 32'd0);
      chk("wait2_resp", 32'(resp), (i == NM - 1) ? 32'hA5 : 32'h5A);
      mem[i] = saved;
      if (i == rst_at) begin
        rst = 1'b1; start_tour = 1'b1; send_resp = 1'b1;
        step();
        rst = 1'b0; start_tour = 1'b0; send_resp = 1'b0; #1;
        chk("rst_busy", 32'(tour_busy), 32'd0);
        chk("rst_idx", 32'(mv_indx), 32'd0);
        chk("rst_cmd", 32'(cmd), 32'(cmd_UART));
        chk("rst_resp", 32'(resp), 32'hA5);
        return;
      end
      send_resp = 1'b1;
      step();
      send_resp = 1'b0;
    end
    noise(); #1;
    chk("end_busy", 32'(tour_busy), 32'd0);
    chk("end_idx", 32'(mv_indx), 32'd0);
    chk("end_resp", 32'(resp), 32'hA5);
    chk("end_cmd", 32'(cmd), 32'(cmd_UART));
    chk("end_rdy", 32'(cmd_rdy), 32'(cmd_rdy_UART));
  endtask

  initial begin
    rst = 1'b1; start_tour = 1'b0; leg_order = 1'b0; clr_cmd_rdy = 1'b0;
    send_resp = 1'b0; cmd_UART = 16'h0000; cmd_rdy_UART = 1'b0;
    mem = '{8'h01, 8'h02, 8'h04, 8'h00};
    step(); step();
    rst = 1'b0; cmd_UART = 16'h1234; cmd_rdy_UART = 1'b1; #1;
    chk("rst_cmd", 32'(cmd), 32'h1234);
    chk("rst_rdy", 32'(cmd_rdy), 32'd1);
    chk("rst_resp", 32'(resp), 32'hA5);
    chk("rst_busy", 32'(tour_busy), 32'd0);
    chk("rst_idx", 32'(mv_indx), 32'd0);

    run_tour(1'b0, -1);
    mem = '{8'h40, 8'h01, 8'h80, 8'h00};
    run_tour(1'b1, -1);
    mem = '{8'h01, 8'h03, 8'h02, 8'h00};
    run_tour(1'b0, -1);
    mem = '{8'h00, 8'h01, 8'h02, 8'h00};
    run_tour(1'b1, -1);
    mem = '{8'h08, 8'h10, 8'h20, 8'h00};
    run_tour(1'b1, 1);

    for (int t = 0; t < 20; t++) begin
      for (int k = 0; k < NM; k++)
        mem[k] = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'(1 << $urandom_range(0, 7));
      repeat ($urandom_range(0, 2)) begin noise(); step(); end
      run_tour(1'($urandom), ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, NM - 1)) : -1);
    end

`ifdef TOUR_ABORT_EN
    mem = '{8'h01, 8'h02, 8'h04, 8'h00};
    cmd_rdy_UART = 1'b0;
    start_tour = 1'b1; step(); start_tour = 1'b0;
    clr_cmd_rdy = 1'b1; step(); clr_cmd_rdy = 1'b0;
    cmd_UART = 16'hF000; cmd_rdy_UART = 1'b1; #1;
    chk("abort_rdy", 32'(cmd_rdy), 32'd0);
    chk("abort_cmd", 32'(cmd), 32'h4002);
    step();
    cmd_rdy_UART = 1'b0; #1;
    chk("abort_busy", 32'(tour_busy), 32'd0);
    chk("abort_idx", 32'(mv_indx), 32'd0);
    chk("abort_resp", 32'(resp), 32'hA5);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
